elevator_scan_scheduler: RTL and testbench

Request-queuing scheduler for the elevator car. Latches floor requests into a pending set and serves them in SCAN order, keeping the current direction while requests remain ahead. It sequences car travel and door timing, and drives the same `current_floor`, `move_up`, `move_down` and `door_open` outputs as the existing three-floor controller, so it drops into the same bench style.

---
 rtl/elevator_pkg.sv | 37 +++
 rtl/elevator_cycle_timer.sv | 37 +++
 rtl/elevator_scan_scheduler.sv | 163 ++++++++++++++++
 tb/tb_elevator_scan_scheduler.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/elevator_pkg.sv
// Shared types and helpers for the elevator SCAN scheduler.
// Floor masks are built at a fixed maximum width and truncated by the user.
package elevator_pkg;

  localparam int MAX_FLOORS = 32;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    MOVE_UP   = 2'd1,
    MOVE_DOWN = 2'd2,
    DOOR      = 2'd3
  } state_e;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  // Bits strictly above floor_idx.
  function automatic logic [MAX_FLOORS-1:0] above_mask(input int floor_idx);
    logic [MAX_FLOORS-1:0] m;
    m = '0;
    for (int i = 0; i < MAX_FLOORS; i++) begin
      if (i > floor_idx) m[i] = 1'b1;
    end
    return m;
  endfunction

  // Bits strictly below floor_idx.
  function automatic logic [MAX_FLOORS-1:0] below_mask(input int floor_idx);
    logic [MAX_FLOORS-1:0] m;
    m = '0;
    for (int i = 0; i < MAX_FLOORS; i++) begin
      if (i < floor_idx) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/elevator_cycle_timer.sv
// Loadable down-counter shared by travel and door timing.
// done flags the edge on which the loaded interval expires.
module elevator_cycle_timer
  import elevator_pkg::*;
#(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             enable,
  output logic             done
);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_value;
    end else if (enable && (count_q != '0)) begin
      count_d = count_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign done = enable && (count_q == WIDTH'(1));

endmodule

// File: rtl/elevator_scan_scheduler.sv
// SCAN-order elevator scheduler: latches floor requests and serves them while
// holding the travel direction as long as requests remain ahead of the car.
module elevator_scan_scheduler
  import elevator_pkg::*;
#(
  parameter int  NUM_FLOORS    = 4,
  parameter int  TRAVEL_CYCLES = 2,
  parameter int  DOOR_CYCLES   = 3,
  localparam int FW            = (NUM_FLOORS > 1) ? $clog2(NUM_FLOORS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_FLOORS-1:0] floor_request,
  output logic [FW-1:0]         current_floor,
  output logic                  move_up,
  output logic                  move_down,
  output logic                  door_open,
  output logic [NUM_FLOORS-1:0] pending,
  output logic                  busy
);

  localparam int MAX_CYC = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
  localparam int CW      = $clog2(MAX_CYC + 1);

  localparam logic [CW-1:0] TRAVEL_LOAD = CW'(TRAVEL_CYCLES);
  localparam logic [CW-1:0] DOOR_LOAD   = CW'(DOOR_CYCLES);
  localparam logic [NUM_FLOORS-1:0] ONE_HOT0 = NUM_FLOORS'(1);

  state_e                state_q, state_d;
  logic [FW-1:0]         floor_q, floor_d;
  logic [NUM_FLOORS-1:0] pending_q, pending_d;
  logic                  dir_q, dir_d;

  logic                  timer_load;
  logic [CW-1:0]         timer_value;
  logic                  timer_en;
  logic                  timer_done;

  logic [NUM_FLOORS-1:0] here_mask;
  logic [NUM_FLOORS-1:0] step_mask;
  logic [NUM_FLOORS-1:0] clear_mask;
  logic [FW-1:0]         step_floor;
  logic                  has_above;
  logic                  has_below;
  logic                  ahead_of_step;

  elevator_cycle_timer #(
    .WIDTH(CW)
  ) u_timer (
    .clk       (clk),
    .rst       (rst),
    .load      (timer_load),
    .load_value(timer_value),
    .enable    (timer_en),
    .done      (timer_done)
  );

  // Geometry of the current floor and of the floor the car would reach next.
  always_comb begin
    step_floor    = (state_q == MOVE_DOWN) ? (floor_q - FW'(1)) : (floor_q + FW'(1));
    here_mask     = ONE_HOT0 << floor_q;
    step_mask     = ONE_HOT0 << step_floor;
    has_above     = |(pending_q & NUM_FLOORS'(above_mask(int'(floor_q))));
    has_below     = |(pending_q & NUM_FLOORS'(below_mask(int'(floor_q))));
    ahead_of_step = (state_q == MOVE_DOWN)
                  ? |(pending_q & NUM_FLOORS'(below_mask(int'(step_floor))))
                  : |(pending_q & NUM_FLOORS'(above_mask(int'(step_floor))));
  end

  always_comb begin
    state_d     = state_q;
    floor_d     = floor_q;
    dir_d       = dir_q;
    clear_mask  = '0;
    timer_load  = 1'b0;
    timer_value = '0;
    timer_en    = 1'b0;

    case (state_q)
      IDLE: begin
        if (|(pending_q & here_mask)) begin
          state_d     = DOOR;
          clear_mask  = here_mask;
          timer_load  = 1'b1;
          timer_value = DOOR_LOAD;
        end else if (has_above && has_below) begin
          state_d     = (dir_q == DIR_UP) ? MOVE_UP : MOVE_DOWN;
          timer_load  = 1'b1;
          timer_value = TRAVEL_LOAD;
        end else if (has_above) begin
          state_d     = MOVE_UP;
          dir_d       = DIR_UP;
          timer_load  = 1'b1;
          timer_value = TRAVEL_LOAD;
        end else if (has_below) begin
          state_d     = MOVE_DOWN;
          dir_d       = DIR_DOWN;
          timer_load  = 1'b1;
          timer_value = TRAVEL_LOAD;
        end
      end

      MOVE_UP, MOVE_DOWN: begin
        timer_en = 1'b1;
        if (timer_done) begin
          floor_d     = step_floor;
          timer_load  = 1'b1;
          timer_value = TRAVEL_LOAD;
          if (|(pending_q & step_mask)) begin
            state_d     = DOOR;
            clear_mask  = step_mask;
            timer_value = DOOR_LOAD;
          end else if (!ahead_of_step) begin
            state_d     = IDLE;
            timer_value = '0;
          end
        end
      end

      DOOR: begin
        // A call for this floor is swallowed and keeps the door open longer.
        clear_mask = here_mask;
        if (|(floor_request & here_mask)) begin
          timer_load  = 1'b1;
          timer_value = DOOR_LOAD;
        end else begin
          timer_en = 1'b1;
          if (timer_done) begin
            state_d = IDLE;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    pending_d = (pending_q | floor_request) & ~clear_mask;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      floor_q   <= '0;
      pending_q <= '0;
      dir_q     <= DIR_UP;
    end else begin
      state_q   <= state_d;
      floor_q   <= floor_d;
      pending_q <= pending_d;
      dir_q     <= dir_d;
    end
  end

  assign current_floor = floor_q;
  assign pending       = pending_q;
  assign move_up       = (state_q == MOVE_UP);
  assign move_down     = (state_q == MOVE_DOWN);
  assign door_open     = (state_q == DOOR);
  assign busy          = (state_q != IDLE) || (|pending_q);

endmodule

// File: tb/tb_elevator_scan_scheduler.sv
// Bench for elevator_scan_scheduler: a cycle-level car model checked every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_elevator_scan_scheduler;

  localparam int NF     = 4;
  localparam int TRAVEL = 2;
  localparam int DOORC  = 3;

  localparam int M_IDLE = 0;
  localparam int M_UP   = 1;
  localparam int M_DOWN = 2;
  localparam int M_DOOR = 3;

  logic          clk;
  logic          rst;
  logic [NF-1:0] floor_request;
  logic [1:0]    current_floor;
  logic          move_up;
  logic          move_down;
  logic          door_open;
  logic [NF-1:0] pending;
  logic          busy;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 0;

  // Behavioural model state.
  int m_floor = 0;
  int m_mode  = M_IDLE;
  int m_left  = 0;
  bit m_dir_up = 1;
  bit m_pend [NF];

  elevator_scan_scheduler #(
    .NUM_FLOORS   (NF),
    .TRAVEL_CYCLES(TRAVEL),
    .DOOR_CYCLES  (DOORC)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .floor_request(floor_request),
    .current_floor(current_floor),
    .move_up      (move_up),
    .move_down    (move_down),
    .door_open    (door_open),
    .pending      (pending),
    .busy         (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
    end
  endtask

  // Request held across exactly one rising edge; called and returns on a negedge.
  task automatic applyStimulus(input logic [NF-1:0] req);
    floor_request = req;
    @(negedge clk);
    floor_request = '0;
  endtask

  task automatic measure(input int n, output int ups, output int dns,
                         output int doors, output int first_door_floor);
    ups = 0;
    dns = 0;
    doors = 0;
    first_door_floor = -1;
    for (int i = 0; i < n; i++) begin
      if (move_up) ups++;
      if (move_down) dns++;
      if (door_open) begin
        doors++;
        if (first_door_floor < 0) first_door_floor = int'(current_floor);
      end
      @(negedge clk);
    end
  endtask

  function automatic int model_pending();
    int v;
    v = 0;
    for (int f = 0; f < NF; f++) begin
      if (m_pend[f]) v = v | (1 << f);
    end
    return v;
  endfunction

  function automatic bit request_beyond(input int from, input bit upward);
    bit found;
    found = 0;
    for (int f = 0; f < NF; f++) begin
      if (m_pend[f] && (upward ? (f > from) : (f < from))) found = 1;
    end
    return found;
  endfunction

  // Car model: what the car must do on each rising edge.
  always @(posedge clk) begin
    int served;
    bit up_any;
    bit dn_any;
    bit newp [NF];
    if (rst) begin
      m_floor  = 0;
      m_mode   = M_IDLE;
      m_left   = 0;
      m_dir_up = 1;
      for (int f = 0; f < NF; f++) m_pend[f] = 0;
    end else begin
      served = -1;
      case (m_mode)
        M_IDLE: begin
          up_any = request_beyond(m_floor, 1);
          dn_any = request_beyond(m_floor, 0);
          if (m_pend[m_floor]) begin
            m_mode = M_DOOR;
            m_left = DOORC;
            served = m_floor;
          end else if (up_any && (!dn_any || m_dir_up)) begin
            m_mode = M_UP;
            m_dir_up = 1;
            m_left = TRAVEL;
          end else if (dn_any) begin
            m_mode = M_DOWN;
            m_dir_up = 0;
            m_left = TRAVEL;
          end
        end
        M_UP, M_DOWN: begin
          m_left--;
          if (m_left == 0) begin
            m_floor = m_floor + ((m_mode == M_UP) ? 1 : -1);
            if (m_pend[m_floor]) begin
              m_mode = M_DOOR;
              m_left = DOORC;
              served = m_floor;
            end else if (request_beyond(m_floor, m_mode == M_UP)) begin
              m_left = TRAVEL;
            end else begin
              m_mode = M_IDLE;
            end
          end
        end
        default: begin
          served = m_floor;
          if (floor_request[m_floor]) begin
            m_left = DOORC;
          end else begin
            m_left--;
            if (m_left == 0) m_mode = M_IDLE;
          end
        end
      endcase
      for (int f = 0; f < NF; f++) newp[f] = (m_pend[f] || floor_request[f]) && (f != served);
      for (int f = 0; f < NF; f++) m_pend[f] = newp[f];
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      checkOutput("cyc_floor", int'(current_floor), m_floor);
      checkOutput("cyc_move_up", int'(move_up), int'(m_mode == M_UP));
      checkOutput("cyc_move_down", int'(move_down), int'(m_mode == M_DOWN));
      checkOutput("cyc_door_open", int'(door_open), int'(m_mode == M_DOOR));
      checkOutput("cyc_pending", int'(pending), model_pending());
      checkOutput("cyc_busy", int'(busy), int'((m_mode != M_IDLE) || (model_pending() != 0)));
      checkOutput("cyc_exclusive", int'(move_up) + int'(move_down) + int'(door_open) <= 1, 1);
    end
  end

  initial begin
    int ups, dns, doors, fdf, k;

    // Reset with every request line high.
    rst = 1'b1;
    floor_request = '1;
    @(negedge clk);
    cmp_en = 1;
    @(negedge clk);
    rst = 1'b0;
    floor_request = '0;
    @(negedge clk);
    checkOutput("rst_floor", int'(current_floor), 0);
    checkOutput("rst_pending", int'(pending), 0);
    checkOutput("rst_outputs", int'({move_up, move_down, door_open}), 0);
    checkOutput("rst_busy", int'(busy), 0);

    // Call at the floor the car already sits on.
    applyStimulus(4'b0001);
    checkOutput("same_pending_e0", int'(pending), 1);
    checkOutput("same_door_e0", int'(door_open), 0);
    measure(6, ups, dns, doors, fdf);
    checkOutput("same_door_cycles", doors, 3);
    checkOutput("same_moves", ups + dns, 0);
    checkOutput("same_pending_end", int'(pending), 0);

    // Full run to the top floor.
    applyStimulus(4'b1000);
    measure(16, ups, dns, doors, fdf);
    checkOutput("long_up_cycles", ups, 6);
    checkOutput("long_door_cycles", doors, 3);
    checkOutput("long_stop_floor", fdf, 3);
    checkOutput("long_final_floor", int'(current_floor), 3);
    checkOutput("long_busy_end", int'(busy), 0);

    // Intermediate stop on the way down, then continue down.
    applyStimulus(4'b0101);
    measure(22, ups, dns, doors, fdf);
    checkOutput("inter_down_cycles", dns, 6);
    checkOutput("inter_door_cycles", doors, 6);
    checkOutput("inter_first_stop", fdf, 2);
    checkOutput("inter_final_floor", int'(current_floor), 0);

    // SCAN preference: a call behind the car waits until the sweep finishes.
    applyStimulus(4'b1000);
    k = 0;
    while (current_floor != 2'd1 && k < 10) begin
      @(negedge clk);
      k++;
    end
    checkOutput("scan_reach_floor1", int'(k < 10), 1);
    applyStimulus(4'b0001);
    measure(30, ups, dns, doors, fdf);
    checkOutput("scan_first_stop", fdf, 3);
    checkOutput("scan_up_remaining", ups, 3);
    checkOutput("scan_down_cycles", dns, 6);
    checkOutput("scan_door_cycles", doors, 6);
    checkOutput("scan_final_floor", int'(current_floor), 0);

    // Door hold: a call for the open floor restarts the door interval.
    applyStimulus(4'b0100);
    k = 0;
    while (!door_open && k < 12) begin
      @(negedge clk);
      k++;
    end
    checkOutput("hold_reach_door", int'(k < 12), 1);
    applyStimulus(4'b0100);
    checkOutput("hold_pending_absorbed", int'(pending), 0);
    measure(6, ups, dns, doors, fdf);
    checkOutput("hold_door_remaining", doors, 3);
    checkOutput("hold_busy_end", int'(busy), 0);

    // Reset while moving up from floor 2.
    applyStimulus(4'b1000);
    k = 0;
    while (!move_up && k < 6) begin
      @(negedge clk);
      k++;
    end
    checkOutput("rstmv_reach_move", int'(k < 6), 1);
    checkOutput("rstmv_floor_before", int'(current_floor), 2);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("rstmv_floor", int'(current_floor), 0);
    checkOutput("rstmv_outputs", int'({move_up, move_down, door_open}), 0);
    checkOutput("rstmv_pending", int'(pending), 0);
    checkOutput("rstmv_busy", int'(busy), 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rstmv_stays_idle", int'(busy), 0);

    cmp_en = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
